// File: rtl/logic_gates_checker_if.sv
// Signal bundle between the logic_gates self-test sequencer and its surroundings.
// The fail_ab member exists only when LOGIC_CHK_STOP_ON_ERR_EN is defined.
interface logic_gates_checker_if;
    logic       start;
    logic       a;
    logic       b;
    logic       out_and;
    logic       out_nand;
    logic       out_or;
    logic       out_nor;
    logic       out_xor;
    logic       out_xnor;
    logic       out_not;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [6:0] fail_vec;
`ifdef LOGIC_CHK_STOP_ON_ERR_EN
    logic [1:0] fail_ab;
`endif

    // Checker side.
    modport slave (
        input  start, out_and, out_nand, out_or, out_nor, out_xor, out_xnor, out_not,
        output a, b, busy, done, pass, err_count, fail_vec
`ifdef LOGIC_CHK_STOP_ON_ERR_EN
        , output fail_ab
`endif
    );

    // Gate block / controller side.
    modport master (
        output start, out_and, out_nand, out_or, out_nor, out_xor, out_xnor, out_not,
        input  a, b, busy, done, pass, err_count, fail_vec
`ifdef LOGIC_CHK_STOP_ON_ERR_EN
        , input fail_ab
`endif
    );
endinterface

// File: rtl/logic_gates_checker.sv
// Self-test sequencer: walks a/b through 00,01,10,11 and compares seven gate outputs to golden.
// Optional LOGIC_CHK_STOP_ON_ERR_EN stops at the first failing vector and reports it on fail_ab.
module logic_gates_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    logic_gates_checker_if.slave bus
);

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] err_q, err_d;
    logic [6:0] fail_q, fail_d;
    logic [6:0] golden, observed, mask;
    logic       a, b;
`ifdef LOGIC_CHK_STOP_ON_ERR_EN
    logic [1:0] fail_ab_q, fail_ab_d;
`endif

    assign a = vec_q[1];
    assign b = vec_q[0];

    // Bit order matches fail_vec: [0]and [1]nand [2]or [3]nor [4]xor [5]xnor [6]not.
    assign golden   = {~a, ~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b};
    assign observed = {bus.out_not, bus.out_xnor, bus.out_xor, bus.out_nor,
                       bus.out_or, bus.out_nand, bus.out_and};
    assign mask     = golden ^ observed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            vec_q     <= 2'd0;
            cnt_q     <= 4'd0;
            err_q     <= 3'd0;
            fail_q    <= 7'd0;
`ifdef LOGIC_CHK_STOP_ON_ERR_EN
            fail_ab_q <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
`ifdef LOGIC_CHK_STOP_ON_ERR_EN
            fail_ab_q <= fail_ab_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        fail_d    = fail_q;
`ifdef LOGIC_CHK_STOP_ON_ERR_EN
        fail_ab_d = fail_ab_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d   = StSettle;
                    vec_d     = 2'd0;
                    cnt_d     = 4'd0;
                    err_d     = 3'd0;
                    fail_d    = 7'd0;
`ifdef LOGIC_CHK_STOP_ON_ERR_EN
                    fail_ab_d = 2'd0;
`endif
                end
            end
            StSettle: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SettleLast) state_d = StSample;
            end
            StSample: begin
                fail_d = fail_q | mask;
                if (|mask) err_d = err_q + 3'd1;
                cnt_d = 4'd0;
                if (vec_q == 2'd3) begin
                    state_d = StDone;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    state_d = StSettle;
                end
`ifdef LOGIC_CHK_STOP_ON_ERR_EN
                if (|mask) begin
                    state_d   = StDone;
                    vec_d     = vec_q;
                    fail_ab_d = vec_q;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q == StSettle) || (state_q == StSample);
        bus.done      = (state_q == StDone);
        bus.pass      = (state_q == StDone) && (err_q == 3'd0);
        bus.a         = a;
        bus.b         = b;
        bus.err_count = err_q;
        bus.fail_vec  = fail_q;
`ifdef LOGIC_CHK_STOP_ON_ERR_EN
        bus.fail_ab   = fail_ab_q;
`endif
    end

endmodule

// File: tb/tb_logic_gates_checker.sv
// Directed bench for logic_gates_checker with a fault-injectable gate model.
// Covers LOGIC_CHK_STOP_ON_ERR_EN builds as well as the default build.
module tb_logic_gates_checker;

    logic clk;
    logic rst;
    int   fault;
    int   n_checks;
    int   n_errors;

    logic_gates_checker_if bus ();

    logic_gates_checker #(
        .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate model: 1 = xor stuck 0, 2 = not wired to ~b, 3 = and stuck 1.
    always_comb begin
        bus.out_and  = bus.a & bus.b;
        bus.out_nand = ~(bus.a & bus.b);
        bus.out_or   = bus.a | bus.b;
        bus.out_nor  = ~(bus.a | bus.b);
        bus.out_xor  = bus.a ^ bus.b;
        bus.out_xnor = ~(bus.a ^ bus.b);
        bus.out_not  = ~bus.a;
        if (fault == 1) bus.out_xor = 1'b0;
        if (fault == 2) bus.out_not = ~bus.b;
        if (fault == 3) bus.out_and = 1'b1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and follow it edge by edge; optionally poke start while busy.
    task automatic run(input bit poke);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_clr_err", 8'(bus.err_count), 8'd0);
        check("start_clr_fail", 8'(bus.fail_vec), 8'd0);
        for (int k = 0; k < 12; k++) begin
            check("ab_seq", 8'({bus.a, bus.b}), 8'(k / 3));
            check("busy_run", 8'(bus.busy), 8'd1);
            check("done_run", 8'(bus.done), 8'd0);
            bus.start = poke;
            tick();
            bus.start = 1'b0;
        end
        check("done_at_12", 8'(bus.done), 8'd1);
        check("busy_done", 8'(bus.busy), 8'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        fault     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        tick();
        tick();
        check("rst_ab", 8'({bus.a, bus.b}), 8'd0);
        check("rst_busy", 8'(bus.busy), 8'd0);
        check("rst_done", 8'(bus.done), 8'd0);
        check("rst_pass", 8'(bus.pass), 8'd0);
        check("rst_err", 8'(bus.err_count), 8'd0);
        check("rst_fail", 8'(bus.fail_vec), 8'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 8'(bus.busy), 8'd0);

        run(1'b0);
        check("good_pass", 8'(bus.pass), 8'd1);
        check("good_err", 8'(bus.err_count), 8'd0);
        check("good_fail", 8'(bus.fail_vec), 8'd0);

`ifdef LOGIC_CHK_STOP_ON_ERR_EN
        fault     = 3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("stop_done_early", 8'(bus.done), 8'd0);
        tick();
        check("stop_done", 8'(bus.done), 8'd1);
        check("stop_err", 8'(bus.err_count), 8'd1);
        check("stop_fail", 8'(bus.fail_vec), 8'b0000001);
        check("stop_fail_ab", 8'(bus.fail_ab), 8'd0);
        check("stop_pass", 8'(bus.pass), 8'd0);
        fault = 0;
        run(1'b0);
        check("rerun_pass", 8'(bus.pass), 8'd1);
        check("rerun_fail_ab", 8'(bus.fail_ab), 8'd0);
`else
        fault = 1;
        run(1'b0);
        check("xor_err", 8'(bus.err_count), 8'd2);
        check("xor_fail", 8'(bus.fail_vec), 8'b0010000);
        check("xor_pass", 8'(bus.pass), 8'd0);

        fault = 2;
        run(1'b0);
        check("not_err", 8'(bus.err_count), 8'd2);
        check("not_fail", 8'(bus.fail_vec), 8'b1000000);
        check("not_pass", 8'(bus.pass), 8'd0);

        // Reset in the middle of vector 10's settle window.
        fault     = 1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        check("mid_ab", 8'({bus.a, bus.b}), 8'b10);
        check("mid_err", 8'(bus.err_count), 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_ab", 8'({bus.a, bus.b}), 8'd0);
        check("mrst_busy", 8'(bus.busy), 8'd0);
        check("mrst_done", 8'(bus.done), 8'd0);
        check("mrst_err", 8'(bus.err_count), 8'd0);
        check("mrst_fail", 8'(bus.fail_vec), 8'd0);
        tick();
        check("mrst_idle", 8'(bus.busy), 8'd0);
        fault = 0;
        run(1'b0);
        check("post_rst_pass", 8'(bus.pass), 8'd1);

        run(1'b1);
        check("poke_pass", 8'(bus.pass), 8'd1);
        check("poke_err", 8'(bus.err_count), 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/logic_gates_checker.md
Name: logic_gates_checker

Overview:
- Hardware self-test sequencer for the logic_gates block; the on-chip counterpart of the gate testbench.
- Drives the a/b inputs of a logic_gates instance through all four combinations and samples its seven outputs against golden values.
- Reports per-gate failures, a count of failing vectors, and pass/done status.
- Sits beside the gate block in the self-test wrapper.

Parameters:
- SETTLE_CYCLES, 2, cycles to hold each a/b vector before sampling. Legal range 1..15; the settle counter is 4 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a test run; sampled only in IDLE or DONE.
- a  output  1  stimulus to gate input a (registered).
- b  output  1  stimulus to gate input b (registered).
- out_and, out_nand, out_or, out_nor, out_xor, out_xnor, out_not  input  1 each  gate outputs under test.
- busy  output  1  high while in SETTLE or SAMPLE.
- done  output  1  high in DONE; held until the next start or rst.
- pass  output  1  done && err_count==0.
- err_count  output  3  number of vectors, 0..4, with at least one mismatching output.
- fail_vec  output  7  sticky per-gate mismatch flags. Bit mapping: [0]and [1]nand [2]or [3]nor [4]xor [5]xnor [6]not.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, a=0, b=0, vec=0, settle counter=0, busy=0, done=0, err_count=0, fail_vec=0. rst overrides every other input, including mid-run; no partial results survive.
- Internal 2-bit vec register; a=vec[1], b=vec[0]. Vector order is 00, 01, 10, 11.
- Golden values per vector:
  - and=a&b, nand=~(a&b)
  - or=a|b, nor=~(a|b)
  - xor=a^b, xnor=~(a^b)
  - not=~a
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: when start=1, go to SETTLE. On that edge: vec=0, a=b=0, counter=0, err_count=0, fail_vec=0.
- SETTLE: counter increments each cycle. When counter==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE, one cycle: compare the seven inputs against the golden values for the current a/b. Update on the exit edge:
  - fail_vec |= mismatch mask
  - err_count += 1 if the mask is nonzero
- SAMPLE exit:
  - vec==3: go to DONE.
  - Otherwise: vec+=1, a/b update on the same edge, counter=0, go to SETTLE.
- DONE: done=1, busy=0. start=1 restarts exactly as from IDLE, clearing results on that edge.
- start while busy is ignored (no restart, no effect).
- Latency: done rises 4*(SETTLE_CYCLES+1) clk edges after the edge that sampled start. Default is 12.
- err_count saturates naturally at 4; no wrap is possible.
- Outputs a/b change only on the state-transition edges described above; no glitching.

Optional Feature:
- Macro: LOGIC_CHK_STOP_ON_ERR_EN.
- Defined:
  - A SAMPLE with a nonzero mismatch mask goes directly to DONE after updating err_count=1 and fail_vec.
  - The remaining vectors are skipped.
  - An extra output, fail_ab [1:0], holds the failing {a,b}. It is reset to 0 and cleared on start.
  - done rises early.
- Undefined: all four vectors always run; fail_ab does not exist.

Test Plan:
- Correct gate model attached, SETTLE_CYCLES=2, start pulse -> done rises 12 cycles later; pass=1, err_count=0, fail_vec=7'b0000000; a/b sequence 00,01,10,11, each held 3 cycles.
- out_xor stuck at 0 -> err_count=2 (vectors 01,10), fail_vec=7'b0010000, pass=0.
- out_not wired to ~b -> mismatches at 01 and 10, so err_count=2, fail_vec=7'b1000000.
- rst asserted during the vector-10 SETTLE -> next cycle: state IDLE, a=b=0, busy=0, done=0, err_count=0, fail_vec=0. A subsequent start runs a full 12-cycle pass.
- start pulsed repeatedly while busy -> no restart, done still at cycle 12. start in DONE -> results cleared on that edge, new run completes 12 cycles later.
- LOGIC_CHK_STOP_ON_ERR_EN defined, out_and stuck at 1 -> stops at vector 00: done at cycle 3, err_count=1, fail_vec=7'b0000001, fail_ab=2'b00.
